// File: rtl/sm4_key_exp.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys, one per clock.
// Define SM4_KEY_ZEROIZE_EN to wipe key state and round keys whenever sm4_enable is low.
module sm4_key_exp (
  input  logic         clk,
  input  logic         rst,
  input  logic         sm4_enable,
  input  logic         key_exp_start,
  input  logic [127:0] key_in,
  output logic [31:0]  rk_00,
  output logic [31:0]  rk_01,
  output logic [31:0]  rk_02,
  output logic [31:0]  rk_03,
  output logic [31:0]  rk_04,
  output logic [31:0]  rk_05,
  output logic [31:0]  rk_06,
  output logic [31:0]  rk_07,
  output logic [31:0]  rk_08,
  output logic [31:0]  rk_09,
  output logic [31:0]  rk_10,
  output logic [31:0]  rk_11,
  output logic [31:0]  rk_12,
  output logic [31:0]  rk_13,
  output logic [31:0]  rk_14,
  output logic [31:0]  rk_15,
  output logic [31:0]  rk_16,
  output logic [31:0]  rk_17,
  output logic [31:0]  rk_18,
  output logic [31:0]  rk_19,
  output logic [31:0]  rk_20,
  output logic [31:0]  rk_21,
  output logic [31:0]  rk_22,
  output logic [31:0]  rk_23,
  output logic [31:0]  rk_24,
  output logic [31:0]  rk_25,
  output logic [31:0]  rk_26,
  output logic [31:0]  rk_27,
  output logic [31:0]  rk_28,
  output logic [31:0]  rk_29,
  output logic [31:0]  rk_30,
  output logic [31:0]  rk_31,
  output logic         key_busy,
  output logic         key_exp_out
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic [0:255][7:0] Sbox = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  localparam logic [127:0] Fk = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // CK byte j of round c is (4c+j)*7 mod 256; the 8-bit product wraps for free.
  function automatic logic [7:0] ck_byte(input logic [4:0] c, input logic [1:0] j);
    logic [7:0] idx;
    idx = {1'b0, c, j};
    return idx * 8'd7;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] k_q [4];
  logic [31:0] rk_q [32];
  logic        key_load, round_en;

  logic [31:0] ck, t_in, t_sub, t_lin, k_next;

  always_comb begin
    ck     = {ck_byte(cnt_q, 2'd0), ck_byte(cnt_q, 2'd1), ck_byte(cnt_q, 2'd2),
              ck_byte(cnt_q, 2'd3)};
    t_in   = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;
    t_sub  = {Sbox[t_in[31:24]], Sbox[t_in[23:16]], Sbox[t_in[15:8]], Sbox[t_in[7:0]]};
    t_lin  = t_sub ^ {t_sub[18:0], t_sub[31:19]} ^ {t_sub[8:0], t_sub[31:9]};
    k_next = k_q[0] ^ t_lin;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_load = 1'b0;
    round_en = 1'b0;
    if (!sm4_enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (key_exp_start) begin
            state_d  = StExpand;
            cnt_d    = 5'd0;
            key_load = 1'b1;
          end
        end
        StExpand: begin
          round_en = 1'b1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      k_q     <= '{default: '0};
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SM4_KEY_ZEROIZE_EN
      if (!sm4_enable) begin
        k_q  <= '{default: '0};
        rk_q <= '{default: '0};
      end else
`endif
      if (key_load) begin
        k_q[0] <= key_in[127:96] ^ Fk[127:96];
        k_q[1] <= key_in[95:64]  ^ Fk[95:64];
        k_q[2] <= key_in[63:32]  ^ Fk[63:32];
        k_q[3] <= key_in[31:0]   ^ Fk[31:0];
      end else if (round_en) begin
        k_q[0]       <= k_q[1];
        k_q[1]       <= k_q[2];
        k_q[2]       <= k_q[3];
        k_q[3]       <= k_next;
        rk_q[cnt_q]  <= k_next;
      end
    end
  end

  assign key_busy    = (state_q == StExpand);
  assign key_exp_out = (state_q == StDone);

  assign rk_00 = rk_q[0];
  assign rk_01 = rk_q[1];
  assign rk_02 = rk_q[2];
  assign rk_03 = rk_q[3];
  assign rk_04 = rk_q[4];
  assign rk_05 = rk_q[5];
  assign rk_06 = rk_q[6];
  assign rk_07 = rk_q[7];
  assign rk_08 = rk_q[8];
  assign rk_09 = rk_q[9];
  assign rk_10 = rk_q[10];
  assign rk_11 = rk_q[11];
  assign rk_12 = rk_q[12];
  assign rk_13 = rk_q[13];
  assign rk_14 = rk_q[14];
  assign rk_15 = rk_q[15];
  assign rk_16 = rk_q[16];
  assign rk_17 = rk_q[17];
  assign rk_18 = rk_q[18];
  assign rk_19 = rk_q[19];
  assign rk_20 = rk_q[20];
  assign rk_21 = rk_q[21];
  assign rk_22 = rk_q[22];
  assign rk_23 = rk_q[23];
  assign rk_24 = rk_q[24];
  assign rk_25 = rk_q[25];
  assign rk_26 = rk_q[26];
  assign rk_27 = rk_q[27];
  assign rk_28 = rk_q[28];
  assign rk_29 = rk_q[29];
  assign rk_30 = rk_q[30];
  assign rk_31 = rk_q[31];

endmodule

// File: tb/tb_sm4_key_exp.sv
// Bench for sm4_key_exp: a whole-key SM4 schedule model plus a per-edge timing model,
// checked every cycle under directed scenarios and randomized traffic.
module tb_sm4_key_exp;

  logic         clk = 1'b0;
  logic         rst, sm4_enable, key_exp_start;
  logic [127:0] key_in;
  logic [31:0]  dut_rk [32];
  logic         key_busy, key_exp_out;

  sm4_key_exp dut (
    .clk(clk), .rst(rst), .sm4_enable(sm4_enable), .key_exp_start(key_exp_start),
    .key_in(key_in),
    .rk_00(dut_rk[0]),  .rk_01(dut_rk[1]),  .rk_02(dut_rk[2]),  .rk_03(dut_rk[3]),
    .rk_04(dut_rk[4]),  .rk_05(dut_rk[5]),  .rk_06(dut_rk[6]),  .rk_07(dut_rk[7]),
    .rk_08(dut_rk[8]),  .rk_09(dut_rk[9]),  .rk_10(dut_rk[10]), .rk_11(dut_rk[11]),
    .rk_12(dut_rk[12]), .rk_13(dut_rk[13]), .rk_14(dut_rk[14]), .rk_15(dut_rk[15]),
    .rk_16(dut_rk[16]), .rk_17(dut_rk[17]), .rk_18(dut_rk[18]), .rk_19(dut_rk[19]),
    .rk_20(dut_rk[20]), .rk_21(dut_rk[21]), .rk_22(dut_rk[22]), .rk_23(dut_rk[23]),
    .rk_24(dut_rk[24]), .rk_25(dut_rk[25]), .rk_26(dut_rk[26]), .rk_27(dut_rk[27]),
    .rk_28(dut_rk[28]), .rk_29(dut_rk[29]), .rk_30(dut_rk[30]), .rk_31(dut_rk[31]),
    .key_busy(key_busy), .key_exp_out(key_exp_out)
  );

  always #5 clk = ~clk;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  typedef logic [31:0] rk_arr_t [32];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = SBOX[x[8*j +: 8]];
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  // Reference key schedule, straight from the SM4 definition.
  function automatic rk_arr_t expand(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    rk_arr_t     r;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      ck = 32'h0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4 * i + j) * 7) % 256)};
      k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      r[i] = k[i+4];
    end
    return r;
  endfunction

  // Timing model: a run started at edge N publishes round key i at edge N+1+i.
  rk_arr_t m_rk, m_ref, ref_a, ref_z, ref_c;
  bit      m_active = 1'b0;
  bit      m_done = 1'b0;
  int      m_age = 0;
  int      n_cmp = 0;
  int      n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic st, input logic [127:0] k);
    rst = r; sm4_enable = en; key_exp_start = st; key_in = k;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_rk[i] = 32'h0;
      m_active = 1'b0; m_done = 1'b0;
    end else if (!en) begin
      m_active = 1'b0; m_done = 1'b0;
`ifdef SM4_KEY_ZEROIZE_EN
      for (int i = 0; i < 32; i++) m_rk[i] = 32'h0;
`endif
    end else if (m_active) begin
      m_rk[m_age] = m_ref[m_age];
      m_age++;
      if (m_age == 32) begin m_active = 1'b0; m_done = 1'b1; end
    end else if (st) begin
      m_ref = expand(k);
      m_active = 1'b1; m_age = 0; m_done = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk($sformatf("rk_%02d", i), dut_rk[i], m_rk[i]);
    chk("key_busy", {31'h0, key_busy}, {31'h0, m_active});
    chk("key_exp_out", {31'h0, key_exp_out}, {31'h0, m_done});
  endtask

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [31:0]  old_rk05;
  logic [127:0] ka;

  initial begin
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, STD_KEY);
    chk("reset_busy", {31'h0, key_busy}, 32'h0);
    chk("reset_done", {31'h0, key_exp_out}, 32'h0);
    chk("reset_rk_17", dut_rk[17], 32'h0);

    // Pin the reference model to the published SM4 vector.
    ref_a = expand(STD_KEY);
    chk("model_rk_00", ref_a[0], 32'hF12186F9);
    chk("model_rk_01", ref_a[1], 32'h41662B61);
    chk("model_rk_31", ref_a[31], 32'h9124A012);

    // Standard vector with cycle-exact timing.
    old_rk05 = dut_rk[5];
    step(1'b0, 1'b1, 1'b1, STD_KEY);
    chk("start_busy", {31'h0, key_busy}, 32'h1);
    for (int c = 1; c <= 32; c++) begin
      step(1'b0, 1'b1, 1'b0, rkey());
      if (c == 5) chk("rk_05_before_n6", dut_rk[5], old_rk05);
      if (c == 6) chk("rk_05_at_n6", dut_rk[5], 32'hF12186F9 ^ 32'hF12186F9 ^ ref_a[5]);
      if (c == 31) chk("done_low_n31", {31'h0, key_exp_out}, 32'h0);
      if (c == 31) chk("busy_high_n31", {31'h0, key_busy}, 32'h1);
    end
    chk("std_done", {31'h0, key_exp_out}, 32'h1);
    chk("std_busy", {31'h0, key_busy}, 32'h0);
    chk("std_rk_00", dut_rk[0], 32'hF12186F9);
    chk("std_rk_01", dut_rk[1], 32'h41662B61);
    chk("std_rk_31", dut_rk[31], 32'h9124A012);
    step(1'b0, 1'b1, 1'b0, '0);

    // Second start mid-expansion must be ignored.
    ka = rkey();
    ref_a = expand(ka);
    step(1'b0, 1'b1, 1'b1, ka);
    for (int c = 1; c <= 5; c++) step(1'b0, 1'b1, 1'b0, rkey());
    step(1'b0, 1'b1, 1'b1, rkey());
    for (int c = 7; c <= 32; c++) step(1'b0, 1'b1, 1'b0, rkey());
    chk("ign_done", {31'h0, key_exp_out}, 32'h1);
    chk("ign_rk_00", dut_rk[0], ref_a[0]);
    chk("ign_rk_31", dut_rk[31], ref_a[31]);

    // Restart from DONE with the all-zero key.
    ref_z = expand('0);
    step(1'b0, 1'b1, 1'b1, '0);
    chk("restart_done_drop", {31'h0, key_exp_out}, 32'h0);
    for (int c = 1; c <= 32; c++) step(1'b0, 1'b1, 1'b0, rkey());
    chk("restart_done", {31'h0, key_exp_out}, 32'h1);
    chk("restart_rk_31", dut_rk[31], ref_z[31]);

    // Abort at EXPAND cycle 10.
    ka = rkey();
    ref_c = expand(ka);
    step(1'b0, 1'b1, 1'b1, ka);
    for (int c = 1; c <= 10; c++) step(1'b0, 1'b1, 1'b0, rkey());
    step(1'b0, 1'b0, 1'b1, rkey());
    chk("abort_busy", {31'h0, key_busy}, 32'h0);
    chk("abort_done", {31'h0, key_exp_out}, 32'h0);
`ifdef SM4_KEY_ZEROIZE_EN
    chk("abort_rk_09", dut_rk[9], 32'h0);
    chk("abort_rk_10", dut_rk[10], 32'h0);
`else
    chk("abort_rk_09", dut_rk[9], ref_c[9]);
    chk("abort_rk_10", dut_rk[10], ref_z[10]);
`endif
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, rkey());
    chk("abort_done_stays", {31'h0, key_exp_out}, 32'h0);

    // Reset at EXPAND cycle 20.
    step(1'b0, 1'b1, 1'b1, rkey());
    for (int c = 1; c <= 20; c++) step(1'b0, 1'b1, 1'b0, rkey());
    step(1'b1, 1'b1, 1'b1, rkey());
    chk("rst_busy", {31'h0, key_busy}, 32'h0);
    chk("rst_done", {31'h0, key_exp_out}, 32'h0);
    chk("rst_rk_00", dut_rk[0], 32'h0);
    chk("rst_rk_31", dut_rk[31], 32'h0);
    step(1'b0, 1'b1, 1'b1, STD_KEY);
    for (int c = 1; c <= 32; c++) step(1'b0, 1'b1, 1'b0, rkey());
    chk("post_rst_rk_31", dut_rk[31], 32'h9124A012);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++)
      step(($urandom % 300) == 0, ($urandom % 40) != 0, ($urandom % 8) == 0, rkey());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
